// File: rtl/stoplight_pkg.sv
// rtl/stoplight_pkg.sv - shared light encodings, phase states and helpers
//
// Package stoplight_pkg, imported by the Stoplight sequencer and by
// crossing_scheduler.
//   light_t  : one-hot signal head encoding (GRN=100, YLW=010, RED=001)
//   phase_t  : intersection phase states
//   max2     : constant helper used to size the phase timer
//   pros_light / wash_light : Moore decode of a phase to each head
`timescale 1ns/1ps
package stoplight_pkg;

  typedef logic [2:0] light_t;

  localparam light_t GRN = 3'b100;
  localparam light_t YLW = 3'b010;
  localparam light_t RED = 3'b001;

  typedef enum logic [2:0] {
    WASH_G = 3'd0,
    WASH_Y = 3'd1,
    ALLR_W = 3'd2,
    PROS_G = 3'd3,
    PROS_Y = 3'd4,
    ALLR_P = 3'd5,
    WALK   = 3'd6
  } phase_t;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic light_t pros_light(phase_t s);
    case (s)
      PROS_G:  return GRN;
      PROS_Y:  return YLW;
      default: return RED;
    endcase
  endfunction

  function automatic light_t wash_light(phase_t s);
    case (s)
      WASH_G:  return GRN;
      WASH_Y:  return YLW;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/crossing_scheduler_if.sv
// rtl/crossing_scheduler_if.sv - sensor/lamp bundle of the crossing scheduler
//
// Signals:
//   car_present : car waiting on Prospect (level)
//   ped_req     : pedestrian button
//   light_pros  : Prospect head, one-hot GRN/YLW/RED
//   light_wash  : Washington head, one-hot GRN/YLW/RED
//   walk        : walk lamp
//   ped_ack     : one-cycle pulse on entry to WALK
// Modports: master drives the sensors and reads the lamps; slave is the
// scheduler side.
`timescale 1ns/1ps
interface crossing_scheduler_if;
  logic       car_present;
  logic       ped_req;
  logic [2:0] light_pros;
  logic [2:0] light_wash;
  logic       walk;
  logic       ped_ack;

  modport master (
    output car_present, ped_req,
    input  light_pros, light_wash, walk, ped_ack
  );

  modport slave (
    input  car_present, ped_req,
    output light_pros, light_wash, walk, ped_ack
  );
endinterface

// File: rtl/crossing_scheduler_phase_timer.sv
// rtl/crossing_scheduler_phase_timer.sv - saturating per-phase cycle counter
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears the count
//   clr : synchronous clear, asserted on the edge that changes phase
//   tmr : cycles spent in the current phase, saturates at all-ones
`timescale 1ns/1ps
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  output logic [W-1:0] tmr
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tmr <= '0;
    end else if (tmr != {W{1'b1}}) begin
      tmr <= tmr + 1'b1;
    end
  end

endmodule

// File: rtl/crossing_scheduler.sv
// rtl/crossing_scheduler.sv - Prospect/Washington phase scheduler
//
// Sequences both signal heads through green, yellow and all-red clearance
// with min/max green enforcement. Washington is the default road; Prospect
// is served on car_present demand.
// Optional feature macro: CROSSING_PED_PHASE_EN adds the pedestrian WALK
// phase, the latched pedestrian request and the last_pros bookkeeping.
// Without it ped_req is ignored and walk/ped_ack stay 0.
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : crossing_scheduler_if.slave (car_present, ped_req in;
//         light_pros, light_wash, walk, ped_ack out)
`timescale 1ns/1ps
module crossing_scheduler
  import stoplight_pkg::*;
#(
  parameter int MIN_GREEN   = 4,
  parameter int MAX_GREEN   = 8,
  parameter int YLW_TIME    = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 3
) (
  input logic                  clk,
  input logic                  rst,
  crossing_scheduler_if.slave  bus
);

  localparam int TMAX = max2(max2(max2(MIN_GREEN, MAX_GREEN),
                                  max2(YLW_TIME, ALLRED_TIME)), WALK_TIME);
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [TW-1:0] MIN_M1  = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_M1  = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YLW_M1  = TW'(YLW_TIME - 1);
  localparam logic [TW-1:0] ALLR_M1 = TW'(ALLRED_TIME - 1);

  phase_t        state;
  phase_t        next_state;
  logic [TW-1:0] tmr;
  logic          ped_pending;
  light_t        light_pros_q;
  light_t        light_wash_q;

  // The timer restarts on exactly the edge that changes phase.
  phase_timer #(.W(TW)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (next_state != state),
    .tmr (tmr)
  );

`ifdef CROSSING_PED_PHASE_EN
  localparam logic [TW-1:0] WALK_M1 = TW'(WALK_TIME - 1);

  logic last_pros;
  logic walk_q;
  logic ped_ack_q;
  logic enter_walk;

  assign enter_walk = (next_state == WALK) && (state != WALK);

  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pending <= 1'b0;
      last_pros   <= 1'b0;
      walk_q      <= 1'b0;
      ped_ack_q   <= 1'b0;
    end else begin
      // Entry into WALK consumes the request; presses during WALK are dropped.
      if (enter_walk) begin
        ped_pending <= 1'b0;
      end else if (bus.ped_req && (state != WALK)) begin
        ped_pending <= 1'b1;
      end
      if ((next_state == PROS_G) && (state != PROS_G)) begin
        last_pros <= 1'b1;
      end else if ((next_state == WASH_G) && (state != WASH_G)) begin
        last_pros <= 1'b0;
      end
      walk_q    <= (next_state == WALK);
      ped_ack_q <= enter_walk;
    end
  end

  assign bus.walk    = walk_q;
  assign bus.ped_ack = ped_ack_q;
`else
  logic unused_ped_req;

  assign unused_ped_req = bus.ped_req;
  assign ped_pending    = 1'b0;
  assign bus.walk       = 1'b0;
  assign bus.ped_ack    = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      WASH_G: if ((tmr >= MIN_M1) && (bus.car_present || ped_pending))
                next_state = WASH_Y;
      WASH_Y: if (tmr == YLW_M1) next_state = ALLR_W;
      ALLR_W: if (tmr == ALLR_M1) begin
`ifdef CROSSING_PED_PHASE_EN
                next_state = ped_pending ? WALK : PROS_G;
`else
                next_state = PROS_G;
`endif
              end
      PROS_G: if ((tmr >= MIN_M1) &&
                  (!bus.car_present || ped_pending || (tmr == MAX_M1)))
                next_state = PROS_Y;
      PROS_Y: if (tmr == YLW_M1) next_state = ALLR_P;
      ALLR_P: if (tmr == ALLR_M1) begin
`ifdef CROSSING_PED_PHASE_EN
                next_state = ped_pending ? WALK : WASH_G;
`else
                next_state = WASH_G;
`endif
              end
`ifdef CROSSING_PED_PHASE_EN
      WALK:   if (tmr == WALK_M1)
                next_state = (!last_pros && bus.car_present) ? PROS_G : WASH_G;
`endif
      default: next_state = WASH_G;
    endcase
  end

  // Lamps are registered alongside the state so they decode the state
  // register's value without a combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WASH_G;
      light_pros_q <= RED;
      light_wash_q <= GRN;
    end else begin
      state        <= next_state;
      light_pros_q <= pros_light(next_state);
      light_wash_q <= wash_light(next_state);
    end
  end

  assign bus.light_pros = light_pros_q;
  assign bus.light_wash = light_wash_q;

endmodule

// File: tb/tb_crossing_scheduler.sv
// tb/tb_crossing_scheduler.sv - directed self-checking bench for crossing_scheduler
`timescale 1ns/1ps
module tb_crossing_scheduler;

  // Observed word: {light_pros, light_wash, walk, ped_ack}
  localparam logic [7:0] WG  = 8'b001_100_00;
  localparam logic [7:0] WY  = 8'b001_010_00;
  localparam logic [7:0] AR  = 8'b001_001_00;
  localparam logic [7:0] PG  = 8'b100_001_00;
  localparam logic [7:0] PY  = 8'b010_001_00;
  localparam logic [7:0] WK1 = 8'b001_001_11;
  localparam logic [7:0] WK  = 8'b001_001_10;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  crossing_scheduler_if bus ();

  crossing_scheduler #(
    .MIN_GREEN   (4),
    .MAX_GREEN   (8),
    .YLW_TIME    (2),
    .ALLRED_TIME (1),
    .WALK_TIME   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #2.5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {bus.light_pros, bus.light_wash, bus.walk, bus.ped_ack};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.car_present = 1'b0;
    bus.ped_req = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] o;
    do_reset();
    o = obs();
    checks++;
    if (o !== WG) begin
      failures++;
      $display("FAIL reset_values got=%b exp=%b", o, WG);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      o = obs();
      checks++;
      if (o !== WG) begin
        failures++;
        $display("FAIL reset_hold[%0d] got=%b exp=%b", i, o, WG);
      end
    end
  endtask

  task automatic test_car_serve();
    logic [7:0] o;
    logic [7:0] exp_tab [14];
    exp_tab = '{WY, WY, AR, PG, PG, PG, PG, PG, PG, PY, PY, AR, WG, WG};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step();
      o = obs();
      checks++;
      if (o !== WG) begin
        failures++;
        $display("FAIL car_idle[%0d] got=%b exp=%b", i, o, WG);
      end
    end
    bus.car_present = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      o = obs();
      checks++;
      if (o !== exp_tab[i]) begin
        failures++;
        $display("FAIL car_serve[%0d] got=%b exp=%b", i, o, exp_tab[i]);
      end
      if (i == 8) bus.car_present = 1'b0;
    end
  endtask

  task automatic test_max_green();
    logic [7:0] o;
    logic [7:0] exp_tab [25];
    exp_tab = '{WG, WG, WG, WY, WY, AR,
                PG, PG, PG, PG, PG, PG, PG, PG,
                PY, PY, AR, WG, WG, WG, WG, WY, WY, AR, PG};
    do_reset();
    bus.car_present = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      o = obs();
      checks++;
      if (o !== exp_tab[i]) begin
        failures++;
        $display("FAIL max_green[%0d] got=%b exp=%b", i, o, exp_tab[i]);
      end
    end
    bus.car_present = 1'b0;
  endtask

`ifdef CROSSING_PED_PHASE_EN
  task automatic test_ped_walk();
    logic [7:0] o;
    logic [7:0] exp_tab [16];
    exp_tab = '{WG, WG, WG, WY, WY, AR, WK1, WK, WK,
                WG, WG, WG, WG, WG, WG, WG};
    do_reset();
    bus.ped_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      o = obs();
      checks++;
      if (o !== exp_tab[i]) begin
        failures++;
        $display("FAIL ped_walk[%0d] got=%b exp=%b", i, o, exp_tab[i]);
      end
      // single press, then a press during WALK which must be dropped
      bus.ped_req = (i == 7);
    end
  endtask

  task automatic test_ped_and_car();
    logic [7:0] o;
    logic [7:0] exp_tab [8];
    int acks = 0;
    exp_tab = '{WY, WY, AR, WK1, WK, WK, PG, PG};
    do_reset();
    for (int i = 0; i < 4; i++) step();
    bus.car_present = 1'b1;
    bus.ped_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      bus.ped_req = 1'b0;
      o = obs();
      if (o[0]) acks++;
      checks++;
      if (o !== exp_tab[i]) begin
        failures++;
        $display("FAIL ped_and_car[%0d] got=%b exp=%b", i, o, exp_tab[i]);
      end
    end
    checks++;
    if (acks !== 1) begin
      failures++;
      $display("FAIL ped_ack_count got=%0d exp=1", acks);
    end
    bus.car_present = 1'b0;
  endtask
`else
  task automatic test_ped_ignored();
    logic [7:0] o;
    do_reset();
    bus.ped_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      o = obs();
      checks++;
      if (o !== WG) begin
        failures++;
        $display("FAIL ped_ignored[%0d] got=%b exp=%b", i, o, WG);
      end
    end
    bus.ped_req = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    logic [7:0] o;
    do_reset();
    bus.car_present = 1'b1;
    for (int i = 0; i < 15; i++) step();
    o = obs();
    checks++;
    if (o !== PY) begin
      failures++;
      $display("FAIL mid_pros_y got=%b exp=%b", o, PY);
    end
    bus.ped_req = 1'b1;
    step();
    o = obs();
    checks++;
    if (o !== PY) begin
      failures++;
      $display("FAIL mid_pros_y2 got=%b exp=%b", o, PY);
    end
    // reset together with a press: reset must win
    bus.car_present = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.ped_req = 1'b0;
    o = obs();
    checks++;
    if (o !== WG) begin
      failures++;
      $display("FAIL mid_reset got=%b exp=%b", o, WG);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      o = obs();
      checks++;
      if (o !== WG) begin
        failures++;
        $display("FAIL mid_no_walk[%0d] got=%b exp=%b", i, o, WG);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.car_present = 1'b0;
    bus.ped_req = 1'b0;
    test_reset();
    test_car_serve();
    test_max_green();
`ifdef CROSSING_PED_PHASE_EN
    test_ped_walk();
    test_ped_and_car();
`else
    test_ped_ignored();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
